// File: rtl/sdram_mc_ctrl.sv
// SDRAM command controller: power-up sequence, round-robin arbitration of
// NCH requesters, single-word ACT/READ/WRITE with auto-precharge, and
// periodic auto-refresh. Command, address and DQ outputs are all registered,
// so the command belonging to a state is on the pins in the cycle that
// state is current.
//
// Requester handshake: a channel raises ireq[k] with iwe/iaddr/iwdata stable
// and holds all of them until oack[k] pulses for one cycle; it must drop
// ireq[k] in that ack cycle. For reads, ordata is valid in the ack cycle and
// holds until the next read completes. A request raised before oinit_done
// simply waits; a reset aborts any access without an ack.
module sdram_mc_ctrl #(
    parameter int NCH          = 2,
    parameter int BA_W         = 2,
    parameter int ROW_W        = 13,
    parameter int COL_W        = 10,
    parameter int DATA_W       = 16,
    parameter int T_INIT       = 20000,
    parameter int TRCD         = 2,
    parameter int CAS_LAT      = 2,
    parameter int TRP          = 2,
    parameter int TRFC         = 7,
    parameter int REF_INTERVAL = 780
) (
    input  logic                            iclk,
    input  logic                            ireset,
    input  logic [NCH-1:0]                  ireq,
    input  logic [NCH-1:0]                  iwe,
    input  logic [NCH*(BA_W+ROW_W+COL_W)-1:0] iaddr,
    input  logic [NCH*DATA_W-1:0]           iwdata,
    output logic [NCH-1:0]                  oack,
    output logic [DATA_W-1:0]               ordata,
    output logic                            oinit_done,
    output logic [ROW_W-1:0]                DRAM_ADDR,
    output logic [BA_W-1:0]                 DRAM_BA,
    output logic                            DRAM_CS_N,
    output logic                            DRAM_RAS_N,
    output logic                            DRAM_CAS_N,
    output logic                            DRAM_WE_N,
    output logic                            DRAM_CKE,
    output logic                            DRAM_LDQM,
    output logic                            DRAM_UDQM,
    input  logic [DATA_W-1:0]               idq,
    output logic [DATA_W-1:0]               odq,
    output logic                            odq_oe
);

    localparam int AW = BA_W + ROW_W + COL_W;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    localparam logic [ROW_W-1:0] A10      = ROW_W'(1024);
    localparam logic [ROW_W-1:0] MODE_REG = ROW_W'((CAS_LAT % 8) * 16);

    typedef enum logic [3:0] {
        ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_REF, ST_INIT_MRS, ST_IDLE,
        ST_ACT, ST_RCD_WAIT, ST_WR, ST_RD, ST_CAS_WAIT, ST_RP_WAIT,
        ST_REF, ST_RFC_WAIT
    } state_t;

    state_t              state, state_d;
    logic [31:0]         cnt, cnt_d;
    logic [3:0]          cmd, cmd_d;
    logic [ROW_W-1:0]    addr_d, cas_addr;
    logic [BA_W-1:0]     ba_d;
    logic [DATA_W-1:0]   odq_d, rd_cap;
    logic                oe_d, ack_set, grant_take, ref_clr, done_set, cap_en, go_cas;
    logic [NCH-1:0]      elig;
    logic                arb_found, arb_we;
    logic [PW-1:0]       arb_idx, rr_ptr, g_idx;
    logic [AW-1:0]       arb_addr;
    logic [DATA_W-1:0]   arb_wdata, g_wdata;
    logic                g_we;
    logic [BA_W-1:0]     g_bank;
    logic [COL_W-1:0]    g_col;
    logic [31:0]         ref_cnt;
    logic                ref_pending, ref_wrap;

    assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = cmd;
    assign DRAM_CKE  = 1'b1;
    assign DRAM_LDQM = 1'b0;
    assign DRAM_UDQM = 1'b0;
    assign cas_addr  = ROW_W'(g_col) | A10;
    // The channel being acked this cycle has already been served.
    assign elig      = ireq & ~oack;
    assign ref_wrap  = oinit_done && (ref_cnt == 32'(REF_INTERVAL - 1));

    // Round-robin search: first eligible channel at or above the pointer, else wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_addr  = '0;
        arb_wdata = '0;
        arb_we    = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (!arb_found && elig[j] && (PW'(j) >= rr_ptr)) begin
                arb_found = 1'b1;
                arb_idx   = PW'(j);
                arb_addr  = iaddr[j*AW +: AW];
                arb_wdata = iwdata[j*DATA_W +: DATA_W];
                arb_we    = iwe[j];
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!arb_found && elig[j] && (PW'(j) < rr_ptr)) begin
                arb_found = 1'b1;
                arb_idx   = PW'(j);
                arb_addr  = iaddr[j*AW +: AW];
                arb_wdata = iwdata[j*DATA_W +: DATA_W];
                arb_we    = iwe[j];
            end
        end
    end

    // Next state, wait counter and the command to register for the next cycle.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 32'd1;
        cmd_d      = CMD_NOP;
        addr_d     = '0;
        ba_d       = '0;
        odq_d      = '0;
        oe_d       = 1'b0;
        ack_set    = 1'b0;
        grant_take = 1'b0;
        ref_clr    = 1'b0;
        done_set   = 1'b0;
        cap_en     = 1'b0;
        go_cas     = 1'b0;
        case (state)
            ST_INIT_WAIT: if (cnt == 32'(T_INIT - 1)) begin
                state_d = ST_INIT_PRE; cnt_d = '0; cmd_d = CMD_PRE; addr_d = A10;
            end
            ST_INIT_PRE: if (cnt == 32'(TRP)) begin
                state_d = ST_INIT_REF; cnt_d = '0; cmd_d = CMD_REF;
            end
            // Two refreshes: one at count 0, the second at count TRFC+1.
            ST_INIT_REF: begin
                if (cnt == 32'(TRFC)) begin
                    cmd_d = CMD_REF;
                end else if (cnt == 32'(2 * TRFC + 1)) begin
                    state_d = ST_INIT_MRS; cnt_d = '0; cmd_d = CMD_MRS; addr_d = MODE_REG;
                end
            end
            ST_INIT_MRS: if (cnt == 32'd2) begin
                state_d = ST_IDLE; cnt_d = '0; done_set = 1'b1;
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (ref_pending) begin
                    state_d = ST_REF; cmd_d = CMD_REF;
                end else if (arb_found) begin
                    state_d    = ST_ACT;
                    cmd_d      = CMD_ACT;
                    ba_d       = arb_addr[COL_W+ROW_W +: BA_W];
                    addr_d     = arb_addr[COL_W +: ROW_W];
                    grant_take = 1'b1;
                end
            end
            ST_ACT: begin
                cnt_d = '0;
                if (TRCD > 1) state_d = ST_RCD_WAIT;
                else          go_cas  = 1'b1;
            end
            ST_RCD_WAIT: if (cnt == 32'(TRCD - 2)) go_cas = 1'b1;
            ST_WR: begin
                state_d = ST_RP_WAIT; cnt_d = '0;
            end
            ST_RD: begin
                state_d = ST_CAS_WAIT; cnt_d = '0;
            end
            // Data arrives CAS_LAT cycles after READ; the read then owes TRP cycles.
            ST_CAS_WAIT: if (cnt == 32'(CAS_LAT - 1)) begin
                cap_en = 1'b1;
                if (TRP == 0) begin
                    state_d = ST_IDLE; cnt_d = '0; ack_set = 1'b1;
                end else begin
                    state_d = ST_RP_WAIT; cnt_d = 32'd1;
                end
            end
            // Writes enter at 0 (TRP+1 NOPs for write recovery), reads at 1 (TRP NOPs).
            ST_RP_WAIT: if (cnt == 32'(TRP)) begin
                state_d = ST_IDLE; cnt_d = '0; ack_set = 1'b1;
            end
            ST_REF: begin
                state_d = ST_RFC_WAIT; cnt_d = '0;
            end
            ST_RFC_WAIT: if (cnt == 32'(TRFC - 1)) begin
                state_d = ST_IDLE; cnt_d = '0; ref_clr = 1'b1;
            end
            default: begin
                state_d = ST_INIT_WAIT; cnt_d = '0;
            end
        endcase
        if (go_cas) begin
            state_d = g_we ? ST_WR : ST_RD;
            cmd_d   = g_we ? CMD_WRITE : CMD_READ;
            ba_d    = g_bank;
            addr_d  = cas_addr;
            odq_d   = g_we ? g_wdata : '0;
            oe_d    = g_we;
        end
    end

    // State register and wait counter.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state <= ST_INIT_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Registered pins, grant latch, read capture and refresh scheduling.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            cmd         <= CMD_NOP;
            DRAM_ADDR   <= '0;
            DRAM_BA     <= '0;
            odq         <= '0;
            odq_oe      <= 1'b0;
            oack        <= '0;
            ordata      <= '0;
            oinit_done  <= 1'b0;
            rr_ptr      <= '0;
            g_idx       <= '0;
            g_we        <= 1'b0;
            g_bank      <= '0;
            g_col       <= '0;
            g_wdata     <= '0;
            rd_cap      <= '0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            cmd       <= cmd_d;
            DRAM_ADDR <= addr_d;
            DRAM_BA   <= ba_d;
            odq       <= odq_d;
            odq_oe    <= oe_d;
            oack      <= ack_set ? (NCH'(1) << g_idx) : '0;
            if (ack_set && !g_we) ordata <= cap_en ? idq : rd_cap;
            if (cap_en) rd_cap <= idq;
            if (done_set) oinit_done <= 1'b1;
            if (grant_take) begin
                g_idx   <= arb_idx;
                g_we    <= arb_we;
                g_bank  <= arb_addr[COL_W+ROW_W +: BA_W];
                g_col   <= arb_addr[COL_W-1:0];
                g_wdata <= arb_wdata;
                rr_ptr  <= (arb_idx == PW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (oinit_done) ref_cnt <= ref_wrap ? '0 : ref_cnt + 32'd1;
            if (ref_wrap)     ref_pending <= 1'b1;
            else if (ref_clr) ref_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_mc_ctrl.sv
// Directed bench for sdram_mc_ctrl: init timing, write/read paths,
// round-robin alternation, refresh around an in-flight read, and reset abort.
// Cycle n is the n-th clock period after the last edge that sampled reset;
// outputs are sampled 1 ns after the edge that starts each cycle.
module tb_sdram_mc_ctrl;

    localparam int NCH = 2, BA_W = 2, ROW_W = 13, COL_W = 10, DATA_W = 16;
    localparam int AW  = BA_W + ROW_W + COL_W;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

    logic                  iclk, ireset;
    logic [NCH-1:0]        ireq, iwe, oack;
    logic [NCH*AW-1:0]     iaddr;
    logic [NCH*DATA_W-1:0] iwdata;
    logic [DATA_W-1:0]     ordata, idq, odq;
    logic                  oinit_done, odq_oe;
    logic [ROW_W-1:0]      dram_addr;
    logic [BA_W-1:0]       dram_ba;
    logic                  cs_n, ras_n, cas_n, we_n, cke, ldqm, udqm;
    logic [3:0]            cmd;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int stray = 0;
    int acks [NCH];
    logic [NCH-1:0] exp_q[$];
    int             exp_cyc_q[$];
    logic [NCH-1:0] exp_ack;
    int             exp_cyc;

    assign cmd = {cs_n, ras_n, cas_n, we_n};

    sdram_mc_ctrl #(
        .NCH(NCH), .BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .T_INIT(20), .TRCD(2), .CAS_LAT(2), .TRP(2), .TRFC(4), .REF_INTERVAL(64)
    ) dut (
        .iclk(iclk), .ireset(ireset), .ireq(ireq), .iwe(iwe), .iaddr(iaddr),
        .iwdata(iwdata), .oack(oack), .ordata(ordata), .oinit_done(oinit_done),
        .DRAM_ADDR(dram_addr), .DRAM_BA(dram_ba), .DRAM_CS_N(cs_n),
        .DRAM_RAS_N(ras_n), .DRAM_CAS_N(cas_n), .DRAM_WE_N(we_n),
        .DRAM_CKE(cke), .DRAM_LDQM(ldqm), .DRAM_UDQM(udqm),
        .idq(idq), .odq(odq), .odq_oe(odq_oe)
    );

    // Clock and watchdog.
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;
    initial begin
        #50000;
        $display("FAIL watchdog: cycle=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic set_req(input int ch, input logic we, input logic [BA_W-1:0] ba,
                           input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                           input logic [DATA_W-1:0] wd);
        iaddr[ch*AW +: AW]          = {ba, row, col};
        iwdata[ch*DATA_W +: DATA_W] = wd;
        iwe[ch]                     = we;
        ireq[ch]                    = 1'b1;
    endtask

    initial begin
        ireset = 1'b1; ireq = '0; iwe = '0; iaddr = '0; iwdata = '0; idq = 16'hDEAD;
        repeat (3) @(posedge iclk);
        #1;
        check("rst_cmd", 32'(cmd), 32'(NOP));
        check("rst_cke_dqm", {cke, ldqm, udqm}, 3'b100);
        check("rst_init_done", 32'(oinit_done), 0);
        check("rst_oack", 32'(oack), 0);
        check("rst_oe_odq", {odq_oe, odq}, 0);
        check("rst_ordata", 32'(ordata), 0);
        check("rst_addr_ba", {dram_ba, dram_addr}, 0);
        ireset = 1'b0;
        cyc = 0;

        // Power-up sequence.
        go_to(19); check("init_nop19", 32'(cmd), 32'(NOP));
        go_to(20); check("init_pre", 32'(cmd), 32'(PRE));
        check("init_pre_a10", 32'(dram_addr), 32'h400);
        go_to(22); check("init_nop22", 32'(cmd), 32'(NOP));
        go_to(23); check("init_ref1", 32'(cmd), 32'(REF));
        go_to(27); check("init_nop27", 32'(cmd), 32'(NOP));
        go_to(28); check("init_ref2", 32'(cmd), 32'(REF));
        go_to(33); check("init_mrs", 32'(cmd), 32'(MRS));
        check("init_mrs_addr", {dram_ba, dram_addr}, 32'h020);
        go_to(35); check("init_done35", 32'(oinit_done), 0);
        go_to(36); check("init_done36", 32'(oinit_done), 1);

        // Channel 0 write.
        go_to(40); set_req(0, 1'b1, 2'd1, 13'h0ABC, 10'h005, 16'hBEEF);
        go_to(41); check("wr_act", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {ACT, 2'b0, 2'd1, 3'b0, 13'h0ABC});
        go_to(42); check("wr_rcd_nop", 32'(cmd), 32'(NOP));
        go_to(43); check("wr_cmd", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {WR, 2'b0, 2'd1, 3'b0, 13'h0405});
        check("wr_dq", {odq_oe, odq}, {1'b1, 16'hBEEF});
        go_to(44); check("wr_oe_off", 32'(odq_oe), 0);
        go_to(46); check("wr_no_ack46", 32'(oack), 0);
        go_to(47); check("wr_ack", 32'(oack), 32'b01);
        ireq[0] = 1'b0;
        go_to(48); check("wr_ack_pulse", 32'(oack), 0);

        // Channel 1 read; idq only holds the right word in the capture cycle.
        go_to(50); set_req(1, 1'b0, 2'd2, 13'h0123, 10'h3FF, 16'h0);
        go_to(51); check("rd_act", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {ACT, 2'b0, 2'd2, 3'b0, 13'h0123});
        go_to(53); check("rd_cmd", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {RD, 2'b0, 2'd2, 3'b0, 13'h07FF});
        check("rd_oe", 32'(odq_oe), 0);
        go_to(55); idq = 16'h1234;
        go_to(56); idq = 16'hDEAD;
        go_to(57); check("rd_no_ack57", {oack, ordata}, 0);
        go_to(58); check("rd_ack", 32'(oack), 32'b10);
        check("rd_data", 32'(ordata), 32'h1234);
        ireq[1] = 1'b0;

        // First periodic refresh while idle.
        go_to(100); check("ref_idle_nop", 32'(cmd), 32'(NOP));
        go_to(101); check("ref_idle", 32'(cmd), 32'(REF));

        // Both channels request continuously; grants must alternate.
        go_to(110);
        set_req(0, 1'b1, 2'd0, 13'h0011, 10'h001, 16'h1111);
        set_req(1, 1'b1, 2'd3, 13'h0022, 10'h002, 16'h2222);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_cyc_q.push_back(117); exp_cyc_q.push_back(124);
        exp_cyc_q.push_back(131); exp_cyc_q.push_back(138);
        acks[0] = 0; acks[1] = 0;
        while (cyc < 150) begin
            tick();
            if (cyc == 118) check("alt_act_ch1", {cmd, 2'b0, dram_ba}, {ACT, 2'b0, 2'd3});
            if (oack != '0) begin
                if (exp_q.size() == 0) begin
                    check("alt_extra_ack", 32'(oack), 0);
                end else begin
                    exp_ack = exp_q.pop_front();
                    exp_cyc = exp_cyc_q.pop_front();
                    check("alt_ack", 32'(oack), 32'(exp_ack));
                    check("alt_ack_cycle", cyc, exp_cyc);
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (oack[c]) begin
                    acks[c]++;
                    ireq[c] = 1'b0;
                end else begin
                    ireq[c] = (acks[c] < 2);
                end
            end
        end
        check("alt_all_acked", exp_q.size(), 0);

        // Refresh counter wraps while a read is in flight.
        go_to(158);
        set_req(1, 1'b0, 2'd1, 13'h0555, 10'h010, 16'h0);
        iaddr[0 +: AW] = {2'd2, 13'h0777, 10'h020};
        iwdata[0 +: DATA_W] = 16'hCAFE;
        iwe[0] = 1'b1;
        go_to(160); ireq[0] = 1'b1;
        go_to(163); idq = 16'h5A5A;
        go_to(164); idq = 16'hDEAD;
        go_to(166); check("refrd_ack", 32'(oack), 32'b10);
        check("refrd_data", 32'(ordata), 32'h5A5A);
        check("refrd_idle_nop", 32'(cmd), 32'(NOP));
        ireq[1] = 1'b0;
        go_to(167); check("refrd_ref", 32'(cmd), 32'(REF));
        go_to(171); check("refrd_rfc_nop", 32'(cmd), 32'(NOP));
        go_to(172); check("refrd_idle2", 32'(cmd), 32'(NOP));
        go_to(173); check("refrd_act", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {ACT, 2'b0, 2'd2, 3'b0, 13'h0777});
        go_to(175); check("refrd_wr", {cmd, 3'b0, dram_addr, odq}, {WR, 3'b0, 13'h0420, 16'hCAFE});
        go_to(179); check("refrd_wr_ack", 32'(oack), 32'b01);
        check("refrd_data_hold", 32'(ordata), 32'h5A5A);
        ireq[0] = 1'b0;

        // Reset in the middle of a read; init replays and a request raised
        // during init is served afterwards.
        go_to(185); set_req(1, 1'b0, 2'd0, 13'h0100, 10'h004, 16'h0);
        go_to(188); check("abort_rd", {cmd, 3'b0, dram_addr}, {RD, 3'b0, 13'h0404});
        go_to(189);
        ireset = 1'b1;
        @(posedge iclk);
        #1;
        ireset = 1'b0;
        ireq = '0;
        cyc = 0;
        check("abort_cmd", 32'(cmd), 32'(NOP));
        check("abort_done", 32'(oinit_done), 0);
        check("abort_ack", 32'(oack), 0);
        stray = 0;
        while (cyc < 36) begin
            tick();
            if (oack != '0) stray++;
            if (cyc == 5) set_req(0, 1'b1, 2'd1, 13'h0042, 10'h008, 16'h7777);
            if (cyc == 20) check("replay_pre", 32'(cmd), 32'(PRE));
            if (cyc == 33) check("replay_mrs", {cmd, 3'b0, dram_addr}, {MRS, 3'b0, 13'h0020});
            if (cyc == 35) check("replay_done35", 32'(oinit_done), 0);
        end
        check("replay_no_ack", stray, 0);
        check("replay_done36", 32'(oinit_done), 1);
        go_to(37); check("held_act", {cmd, 2'b0, dram_ba, 3'b0, dram_addr}, {ACT, 2'b0, 2'd1, 3'b0, 13'h0042});
        go_to(39); check("held_wr", {cmd, 3'b0, dram_addr, odq}, {WR, 3'b0, 13'h0408, 16'h7777});
        go_to(43); check("held_ack", 32'(oack), 32'b01);
        ireq[0] = 1'b0;
        go_to(45);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
